// File: rtl/btn_pkg.sv
// btn_pkg: state type and default constants shared by the button press classifier
package btn_pkg;
  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } btn_class_state_t;
  localparam int BTN_LONG_CYCLES_DEF = 50_000_000;
  localparam int BTN_DOUBLE_GAP_DEF  = 25_000_000;
  localparam int BTN_CNT_W_DEF       = 27;
endpackage

// File: rtl/btn_edge_detect.sv
// btn_edge_detect: registers the button level and flags rising/falling edges
module btn_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_state,
  output logic rise,
  output logic fall
);
  logic btn_q, btn_d;
  always_comb btn_d = btn_state;
  // resets to pressed so a button held through reset must be released before it counts
  always_ff @(posedge clk) begin
    if (!rst_n) btn_q <= 1'b1;
    else        btn_q <= btn_d;
  end
  assign rise = btn_state & ~btn_q;
  assign fall = ~btn_state & btn_q;
endmodule

// File: rtl/btn_press_classifier.sv
// btn_press_classifier: turns a debounced button level into short/long/double press pulses
// Double-press detection is compiled in by defining BTN_CLASS_DOUBLE_EN.
module btn_press_classifier
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES       = BTN_LONG_CYCLES_DEF,
  parameter int DOUBLE_GAP_CYCLES = BTN_DOUBLE_GAP_DEF,
  parameter int CNT_W             = BTN_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_state,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP_CYCLES - 1);
  btn_class_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic short_q, short_d, long_q, long_d, double_q, double_d, busy_q, busy_d;
  logic rise, fall, cnt_hit;
  btn_edge_detect u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_state(btn_state),
    .rise     (rise),
    .fall     (fall)
  );
  // one comparator serves both timeouts; the limit follows the state that owns the counter
  assign cnt_hit = cnt_q == (state_q == WAIT_SECOND ? GAP_LAST : LONG_LAST);
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    case (state_q)
      IDLE: if (rise) state_d = PRESSED;
      PRESSED:
        if (fall) begin
`ifdef BTN_CLASS_DOUBLE_EN
          state_d = WAIT_SECOND;
`else
          state_d = IDLE;
          short_d = 1'b1;
`endif
        end else if (cnt_hit) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end
      LONG_HELD: if (fall) state_d = IDLE;
`ifdef BTN_CLASS_DOUBLE_EN
      WAIT_SECOND:
        if (btn_state) state_d = SECOND_PRESSED;
        else if (cnt_hit) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      SECOND_PRESSED:
        if (fall) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end
`endif
      default: state_d = IDLE;
    endcase
    cnt_d  = state_d != state_q ? '0 :
             (state_q == PRESSED || state_q == WAIT_SECOND) && !(&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      busy_q   <= busy_d;
    end
  end
  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_btn_press_classifier.sv
// tb_btn_press_classifier: directed and random press patterns checked cycle by cycle against a press/gap timing model
module tb_btn_press_classifier;
  localparam int LONG = 8;
  localparam int GAP  = 4;
`ifdef BTN_CLASS_DOUBLE_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif
  localparam logic [3:0] EV_SHORT = 4'b1000, EV_LONG = 4'b0100, EV_DOUBLE = 4'b0010, EV_BUSY = 4'b0001;
  logic clk = 1'b0, rst_n = 1'b0, btn_state = 1'b0;
  logic short_press, long_press, double_press, busy;
  int errors = 0, checks = 0;
  bit stim_q[$];
  logic [3:0] exp_q[$], act_q[$];

  btn_press_classifier #(.LONG_CYCLES(LONG), .DOUBLE_GAP_CYCLES(GAP), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_state   (btn_state),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic add(input bit v, input int n);
    for (int i = 0; i < n; i++) stim_q.push_back(v);
  endtask

  task automatic do_reset(input bit b);
    rst_n = 1'b0;
    btn_state = b;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_stim();
    act_q = {};
    for (int i = 0; i < stim_q.size(); i++) begin
      btn_state = stim_q[i];
      @(posedge clk);
      #1;
      act_q.push_back({short_press, long_press, double_press, busy});
    end
  endtask

  // Expected outputs from press/release times: the level before the pattern is taken as
  // pressed, matching the post-reset edge detector state.
  task automatic build_exp();
    int n = stim_q.size();
    int ps[$], rs[$];
    int k = 0;
    bit p = 1'b1;
    exp_q = {};
    for (int i = 0; i < n; i++) exp_q.push_back(4'b0);
    for (int i = 0; i < n; i++) begin
      if (stim_q[i] && !p) ps.push_back(i);
      if (!stim_q[i] && p && ps.size() > rs.size()) rs.push_back(i);
      p = stim_q[i];
    end
    if (rs.size() < ps.size()) rs.push_back(n);
    while (k < ps.size()) begin
      int pp = ps[k], r = rs[k], ev_t, done;
      logic [3:0] ev;
      if (r - pp > LONG) begin
        ev_t = pp + LONG; ev = EV_LONG; done = r; k++;
      end else if (!DBL) begin
        ev_t = r; ev = EV_SHORT; done = r; k++;
      end else if (k + 1 < ps.size() && ps[k+1] - r <= GAP) begin
        ev_t = rs[k+1]; ev = EV_DOUBLE; done = ev_t; k += 2;
      end else begin
        ev_t = r + GAP; ev = EV_SHORT; done = ev_t; k++;
      end
      for (int i = pp; i < done && i < n; i++) exp_q[i] = exp_q[i] | EV_BUSY;
      if (ev_t < n) exp_q[ev_t] = exp_q[ev_t] | ev;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_state = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({short_press, long_press, double_press, busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000", {short_press, long_press, double_press, busy});
    end
    rst_n = 1'b1;
    stim_q = {};
    add(1, 20); add(0, 3);
    run_stim();
    build_exp();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL held_through_reset cyc %0d got %b want %b", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_short();
    do_reset(0);
    stim_q = {};
    add(0, 2); add(1, 3); add(0, 10);
    run_stim();
    build_exp();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL short cyc %0d got %b want %b", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_long();
    do_reset(0);
    stim_q = {};
    add(0, 2); add(1, 12); add(0, 8); add(1, 9); add(0, 3); add(1, 8); add(0, 8);
    run_stim();
    build_exp();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL long cyc %0d got %b want %b", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_double();
    do_reset(0);
    stim_q = {};
    add(0, 2); add(1, 2); add(0, 2); add(1, 2); add(0, 10);
    run_stim();
    build_exp();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL double cyc %0d got %b want %b", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_gap_boundary();
    do_reset(0);
    stim_q = {};
    add(0, 2); add(1, 3); add(0, 4); add(1, 2); add(0, 8);
    add(1, 3); add(0, 5); add(1, 2); add(0, 10);
    run_stim();
    build_exp();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL gap_boundary cyc %0d got %b want %b", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(0);
    stim_q = {};
    add(0, 2); add(1, 6);
    run_stim();
    build_exp();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mid_reset_pre cyc %0d got %b want %b", i, act_q[i], exp_q[i]);
      end
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({short_press, long_press, double_press, busy} !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %b want 0000", {short_press, long_press, double_press, busy});
    end
    rst_n = 1'b1;
    stim_q = {};
    add(1, 10); add(0, 3); add(1, 3); add(0, 10);
    run_stim();
    build_exp();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mid_reset_post cyc %0d got %b want %b", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset(0);
      stim_q = {};
      add(0, 2);
      for (int p = 0; p < 6; p++) begin
        add(1, $urandom_range(12, 1));
        add(0, $urandom_range(7, 1));
      end
      add(0, 12);
      run_stim();
      build_exp();
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (act_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random round %0d cyc %0d got %b want %b", r, i, act_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double();
    test_gap_boundary();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
